// File: rtl/fmul_ctrl_pkg.sv
// Shared definitions for the fmul sharing controller: FSM state encoding,
// requester count, default multiplier settle time and settle-counter width.
package fmul_ctrl_pkg;

    // Number of requesters sharing the multiplier.
    localparam int NUM_REQ     = 2;

    // Default number of cycles the operands are held before the result is sampled.
    localparam int MUL_LAT_DEF = 2;

    // Width of the settle counter; bounds the largest usable MUL_LAT to 2**CNT_W.
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fmul_arbiter_rr_arb2.sv
// Two-input round-robin grant. The result is purely combinational; the
// priority pointer is owned by the instantiating controller.
module rr_arb2
    import fmul_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    // A lone request always wins; the pointer only breaks a tie.
    always_comb begin
        grant = req_valid;
        if (&req_valid) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/fmul_arbiter.sv
// Shares one combinational fmul between two requesters. One operation at a
// time is accepted, its operands are held on the multiplier for MUL_LAT
// cycles, the result is captured and returned to the owning requester.
// Optional build macro FMUL_ARB_STATS_EN adds saturating per-requester
// completion counters grant_cnt0 / grant_cnt1.
module fmul_arbiter
    import fmul_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*W-1:0] req_op_a,
    input  logic [NUM_REQ*W-1:0] req_op_b,
    input  logic [NUM_REQ-1:0]   req_mode_fp,
    input  logic [NUM_REQ-1:0]   req_round_mode,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [W-1:0]         mul_op_a,
    output logic [W-1:0]         mul_op_b,
    output logic                 mul_mode_fp,
    output logic                 mul_round_mode,
    input  logic [W-1:0]         mul_re,
`ifdef FMUL_ARB_STATS_EN
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1,
`endif
    output logic                 busy
);

    generate
        if (MUL_LAT < 1) begin : g_lat_too_small
            $error("fmul_arbiter: MUL_LAT must be at least 1");
        end
        if (MUL_LAT > (1 << CNT_W)) begin : g_lat_too_large
            $error("fmul_arbiter: MUL_LAT exceeds the settle counter range");
        end
    endgenerate

    // Counter load on acceptance: reaching zero marks the sampling edge.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    state_t             state_q;
    state_t             state_d;
    logic               owner_q;   // requester that owns the operation in flight
    logic               ptr_q;     // requester favoured on a tie
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] grant;
    logic               sel;
    logic               accept;
    logic               capture;
    logic               complete;

    rr_arb2 u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant)
    );

    // Index of the granted requester; only meaningful while accept is high.
    assign sel  = grant[1];
    assign busy = (state_q != IDLE);

    // Next-state logic plus the request/response handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = grant;
                accept    = |grant;
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                // Only the owner's ready matters; the other bit is ignored.
                if (rsp_ready[owner_q]) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner, round-robin pointer and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                owner_q <= sel;
                cnt_q   <= CNT_LOAD;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // The pointer moves only when a response is consumed, so a
            // requester stuck in backpressure cannot lose its turn early.
            if (complete) begin
                ptr_q <= ~owner_q;
            end
        end
    end

    // Operand registers driving the multiplier and the captured result;
    // both keep their last value between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_op_a       <= '0;
            mul_op_b       <= '0;
            mul_mode_fp    <= 1'b0;
            mul_round_mode <= 1'b0;
            rsp_data       <= '0;
        end else begin
            if (accept) begin
                mul_op_a       <= sel ? req_op_a[2*W-1:W] : req_op_a[W-1:0];
                mul_op_b       <= sel ? req_op_b[2*W-1:W] : req_op_b[W-1:0];
                mul_mode_fp    <= req_mode_fp[sel];
                mul_round_mode <= req_round_mode[sel];
            end
            if (capture) begin
                rsp_data <= mul_re;
            end
        end
    end

`ifdef FMUL_ARB_STATS_EN
    // Saturating count of completed responses per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (complete) begin
            if (!owner_q && (grant_cnt0 != 16'hFFFF)) begin
                grant_cnt0 <= grant_cnt0 + 16'd1;
            end
            if (owner_q && (grant_cnt1 != 16'hFFFF)) begin
                grant_cnt1 <= grant_cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model. A behavioural fmul is attached to the
// mul_* ports of each instance (MUL_LAT=2 and MUL_LAT=1).
`timescale 1ns/1ps
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))
module tb_fmul_arbiter;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [1:0]     req_valid, req_ready, req_mode_fp, req_round_mode;
    logic [1:0]     rsp_valid, rsp_ready;
    logic [2*W-1:0] req_op_a, req_op_b;
    logic [W-1:0]   rsp_data, mul_op_a, mul_op_b, mul_re;
    logic           mul_mode_fp, mul_round_mode, busy;

    logic [1:0]     req_valid1, req_ready1, rsp_valid1, rsp_ready1;
    logic [W-1:0]   rsp_data1, mul_op_a1, mul_op_b1, mul_re1;
    logic           mul_mode_fp1, mul_round_mode1, busy1;
`ifdef FMUL_ARB_STATS_EN
    logic [15:0]    gc0, gc1, gc0_1, gc1_1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state for the randomized phase.
    bit          pend [2];
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic        rfp [2];
    logic        rrm [2];
    bit          infl, do_acc, do_done;
    int          own, age, win, last_srv;
    logic [31:0] exp_d;
    logic [1:0]  exp_rdy, exp_rv;

    // Behavioural multiplier: float32 (truncate or round-half-up) when fp=1,
    // low word of the integer product when fp=0.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b,
                                             input logic fp, input logic rm);
        logic [47:0] p;
        logic [23:0] m;
        logic        g;
        logic        s;
        int          e;
        if (!fp) return a * b;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; e = e + 1;
        end else begin
            m = p[46:23]; g = p[22];
        end
        if (rm && g) begin
            if (m == 24'hFFFFFF) begin
                m = 24'h800000; e = e + 1;
            end else begin
                m = m + 24'd1;
            end
        end
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hFF, 23'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    assign mul_re  = fmul_ref(mul_op_a, mul_op_b, mul_mode_fp, mul_round_mode);
    assign mul_re1 = fmul_ref(mul_op_a1, mul_op_b1, mul_mode_fp1, mul_round_mode1);

    fmul_arbiter #(.MUL_LAT(LAT), .W(W)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_mode_fp    (req_mode_fp),
        .req_round_mode (req_round_mode),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .mul_op_a       (mul_op_a),
        .mul_op_b       (mul_op_b),
        .mul_mode_fp    (mul_mode_fp),
        .mul_round_mode (mul_round_mode),
        .mul_re         (mul_re),
`ifdef FMUL_ARB_STATS_EN
        .grant_cnt0     (gc0),
        .grant_cnt1     (gc1),
`endif
        .busy           (busy)
    );

    fmul_arbiter #(.MUL_LAT(1), .W(W)) u_dut_l1 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid1),
        .req_ready      (req_ready1),
        .req_op_a       (req_op_a),
        .req_op_b       (req_op_b),
        .req_mode_fp    (req_mode_fp),
        .req_round_mode (req_round_mode),
        .rsp_valid      (rsp_valid1),
        .rsp_ready      (rsp_ready1),
        .rsp_data       (rsp_data1),
        .mul_op_a       (mul_op_a1),
        .mul_op_b       (mul_op_b1),
        .mul_mode_fp    (mul_mode_fp1),
        .mul_round_mode (mul_round_mode1),
        .mul_re         (mul_re1),
`ifdef FMUL_ARB_STATS_EN
        .grant_cnt0     (gc0_1),
        .grant_cnt1     (gc1_1),
`endif
        .busy           (busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic fp, input logic rm);
        if (i == 0) begin
            req_op_a[31:0] = a;
            req_op_b[31:0] = b;
        end else begin
            req_op_a[63:32] = a;
            req_op_b[63:32] = b;
        end
        req_mode_fp[i]    = fp;
        req_round_mode[i] = rm;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        rsp_ready  = '0;
        req_valid1 = '0;
        rsp_ready1 = '0;
        rst_n      = 1'b0;
        tick();
        rst_n      = 1'b1;
    endtask

    // Bounded wait for rsp_valid[idx] on the MUL_LAT=2 instance.
    task automatic wait_rsp(input int idx, input string tag);
        int k = 0;
        while (!rsp_valid[idx] && k < 20) begin
            tick();
            k++;
        end
        `CHK(tag, rsp_valid[idx], 1'b1);
    endtask

    // Issue one float op from requester idx and consume its response.
    task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b);
        set_req(idx, a, b, 1'b1, 1'b0);
        req_valid      = '0;
        req_valid[idx] = 1'b1;
        #1 `CHK("op_ready", req_ready[idx], 1'b1);
        tick();
        req_valid = '0;
        wait_rsp(idx, "op_rsp_valid");
        `CHK("op_rsp_data", rsp_data, fmul_ref(a, b, 1'b1, 1'b0));
        rsp_ready      = '0;
        rsp_ready[idx] = 1'b1;
        tick();
        rsp_ready = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: summary not reached within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        req_valid      = '0;
        req_valid1     = '0;
        rsp_ready      = '0;
        rsp_ready1     = '0;
        req_op_a       = '0;
        req_op_b       = '0;
        req_mode_fp    = '0;
        req_round_mode = '0;
        #1;
        // ---- reset state ----
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_rsp_valid", rsp_valid, 2'b00);
        `CHK("rst_rsp_data", rsp_data, 32'h0);
        `CHK("rst_mul_a", mul_op_a, 32'h0);
        `CHK("rst_mul_b", mul_op_b, 32'h0);
        `CHK("rst_mul_modes", {mul_mode_fp, mul_round_mode}, 2'b00);
        `CHK("rst_req_ready", req_ready, 2'b00);
        `CHK("rst_busy_l1", busy1, 1'b0);
        tick();
        rst_n = 1'b1;

        // ---- single op, MUL_LAT=2 ----
        tick();
        set_req(0, 32'h3f800000, 32'h40000000, 1'b1, 1'b0);
        req_valid = 2'b01;
        #1 `CHK("single_req_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        `CHK("single_busy", busy, 1'b1);
        `CHK("single_mul_a", mul_op_a, 32'h3f800000);
        `CHK("single_mul_b", mul_op_b, 32'h40000000);
        `CHK("single_mul_fp", mul_mode_fp, 1'b1);
        `CHK("single_rsp_e0", rsp_valid, 2'b00);
        `CHK("single_ready_wait", req_ready, 2'b00);
        tick();
        `CHK("single_rsp_e1", rsp_valid, 2'b00);
        tick();
        `CHK("single_rsp_valid", rsp_valid, 2'b01);
        `CHK("single_rsp_data", rsp_data, 32'h40000000);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = '0;
        `CHK("single_busy_after", busy, 1'b0);
        `CHK("single_rsp_after", rsp_valid, 2'b00);
        `CHK("single_mul_held", mul_op_a, 32'h3f800000);
        `CHK("single_data_held", rsp_data, 32'h40000000);

        // ---- contention out of reset ----
        do_reset();
        set_req(0, 32'h40400000, 32'h40800000, 1'b1, 1'b0);
        set_req(1, 32'h40000000, 32'h40000000, 1'b1, 1'b0);
        req_valid = 2'b11;
        #1 `CHK("cont_grant_first", req_ready, 2'b01);
        tick();
        req_valid = 2'b10;
        rsp_ready = 2'b11;
        #1 `CHK("cont_ready_busy", req_ready, 2'b00);
        wait_rsp(0, "cont_rsp0_valid");
        `CHK("cont_rsp0_data", rsp_data, 32'h41400000);
        tick();
        `CHK("cont_grant_second", req_ready, 2'b10);
        tick();
        req_valid = '0;
        wait_rsp(1, "cont_rsp1_valid");
        `CHK("cont_rsp1_data", rsp_data, 32'h40800000);
        tick();
        req_valid = 2'b11;
        #1 `CHK("cont_grant_third", req_ready, 2'b01);
        tick();
        req_valid = '0;
        wait_rsp(0, "cont_rsp3_valid");
        tick();

        // ---- response backpressure on requester 1 ----
        rsp_ready = '0;
        set_req(1, 32'h3f800000, 32'h40400000, 1'b1, 1'b0);
        req_valid = 2'b10;
        #1 `CHK("bp_grant1", req_ready, 2'b10);
        tick();
        req_valid = '0;
        wait_rsp(1, "bp_rsp_valid");
        set_req(0, 32'h40000000, 32'h40400000, 1'b1, 1'b0);
        req_valid = 2'b01;
        #1;
        for (int k = 0; k < 5; k++) begin
            `CHK("bp_rsp_valid_hold", rsp_valid, 2'b10);
            `CHK("bp_rsp_data_hold", rsp_data, 32'h40400000);
            `CHK("bp_req_ready_low", req_ready, 2'b00);
            tick();
        end
        rsp_ready = 2'b11;
        tick();
        rsp_ready = '0;
        `CHK("bp_pending_granted", req_ready, 2'b01);
        tick();
        req_valid = '0;
        `CHK("bp_accepted_busy", busy, 1'b1);
        `CHK("bp_mul_a", mul_op_a, 32'h40000000);

        // ---- reset abort during WAIT ----
        rst_n = 1'b0;
        #1;
        `CHK("abort_busy", busy, 1'b0);
        `CHK("abort_mul_a", mul_op_a, 32'h0);
        `CHK("abort_rsp_data", rsp_data, 32'h0);
        `CHK("abort_rsp_valid", rsp_valid, 2'b00);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            tick();
            `CHK("abort_no_rsp", rsp_valid, 2'b00);
        end

        // ---- MUL_LAT=1 instance ----
        set_req(0, 32'h3f800000, 32'h40000000, 1'b1, 1'b0);
        req_valid1 = 2'b01;
        #1 `CHK("l1_req_ready", req_ready1, 2'b01);
        tick();
        req_valid1 = '0;
        `CHK("l1_rsp_e0", rsp_valid1, 2'b00);
        tick();
        `CHK("l1_rsp_valid", rsp_valid1, 2'b01);
        `CHK("l1_rsp_data", rsp_data1, 32'h40000000);
        rsp_ready1 = 2'b01;
        tick();
        rsp_ready1 = '0;
        `CHK("l1_busy_after", busy1, 1'b0);

        // ---- completion counting: 3 ops from req0, 2 from req1 ----
        do_reset();
        do_op(0, 32'h40000000, 32'h40400000);
        do_op(1, 32'h40400000, 32'h40400000);
        do_op(0, 32'h3fc00000, 32'h40000000);
        do_op(1, 32'h40800000, 32'h3f000000);
        do_op(0, 32'hc0000000, 32'h40a00000);
`ifdef FMUL_ARB_STATS_EN
        `CHK("stats_cnt0", gc0, 16'd3);
        `CHK("stats_cnt1", gc1, 16'd2);
`endif

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        infl     = 1'b0;
        do_acc   = 1'b0;
        do_done  = 1'b0;
        last_srv = 1;   // so that a tie right after reset goes to requester 0
        own      = 0;
        age      = 0;
        win      = 0;
        exp_d    = '0;
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; ra[i] = '0; rb[i] = '0; rfp[i] = 1'b0; rrm[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (do_acc) begin
                infl      = 1'b1;
                own       = win;
                age       = 0;
                exp_d     = fmul_ref(ra[win], rb[win], rfp[win], rrm[win]);
                pend[win] = 1'b0;
            end else if (do_done) begin
                infl     = 1'b0;
                last_srv = own;
            end else if (infl) begin
                age++;
            end
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ra[i]   = $urandom;
                    rb[i]   = $urandom;
                    rfp[i]  = 1'($urandom_range(0, 1));
                    rrm[i]  = 1'($urandom_range(0, 1));
                end
                set_req(i, ra[i], rb[i], rfp[i], rrm[i]);
            end
            req_valid = {pend[1], pend[0]};
            rsp_ready = 2'($urandom_range(0, 3));
            #1;
            exp_rdy = '0;
            exp_rv  = '0;
            if (!infl) begin
                if (pend[0] && pend[1]) win = (last_srv == 0) ? 1 : 0;
                else if (pend[1])       win = 1;
                else                    win = 0;
                if (pend[0] || pend[1]) exp_rdy[win] = 1'b1;
            end else if (age >= LAT) begin
                exp_rv[own] = 1'b1;
            end
            n_cmp++;
            if (req_ready !== exp_rdy) begin
                n_bad++;
                $error("FAIL rnd_req_ready: observed=%0h expected=%0h", req_ready, exp_rdy);
            end
            n_cmp++;
            if (rsp_valid !== exp_rv) begin
                n_bad++;
                $error("FAIL rnd_rsp_valid: observed=%0h expected=%0h", rsp_valid, exp_rv);
            end
            n_cmp++;
            if (busy !== infl) begin
                n_bad++;
                $error("FAIL rnd_busy: observed=%0h expected=%0h", busy, infl);
            end
            if (exp_rv != 2'b00) begin
                n_cmp++;
                if (rsp_data !== exp_d) begin
                    n_bad++;
                    $error("FAIL rnd_rsp_data: observed=%0h expected=%0h", rsp_data, exp_d);
                end
            end
            do_acc  = (exp_rdy != 2'b00);
            do_done = (exp_rv != 2'b00) && rsp_ready[own];
            tick();
        end
        req_valid = '0;
        rsp_ready = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fmul_arbiter.md
Name: fmul_arbiter

Overview:
- Sequences and shares one combinational fmul datapath (op_a, op_b, mode_fp, round_mode → re) between two requesters.
- Accepts one operation at a time through a valid/ready handshake.
- Holds the operands stable on the multiplier for a programmable settle time, captures the result, and returns it on a per-requester response handshake.
- Sits between the issue logic of two FP units and a single shared fmul instance.

Parameters:
- MUL_LAT, 2: cycles the operands are held before `mul_re` is sampled. Must be ≥1; values below 1 are an elaboration error.
- W, 32: operand and result width.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  2  — request valid; bit i belongs to requester i.
- `req_ready`  out  2  — request accepted when `req_valid[i] & req_ready[i]`.
- `req_op_a`  in  2*W  — operand A; [W-1:0] is requester 0, [2W-1:W] is requester 1.
- `req_op_b`  in  2*W  — operand B, same packing as `req_op_a`.
- `req_mode_fp`  in  2  — per-requester precision mode, passed through to fmul.
- `req_round_mode`  in  2  — per-requester rounding mode, passed through to fmul.
- `rsp_valid`  out  2  — result available for requester i.
- `rsp_ready`  in  2  — requester i consumes the result.
- `rsp_data`  out  W  — result. Meaningful only while some `rsp_valid` bit is high.
- `mul_op_a`  out  W  — to fmul `op_a`.
- `mul_op_b`  out  W  — to fmul `op_b`.
- `mul_mode_fp`  out  1  — to fmul `mode_fp`.
- `mul_round_mode`  out  1  — to fmul `round_mode`.
- `mul_re`  in  W  — from fmul `re`.
- `busy`  out  1  — high whenever state ≠ IDLE.

Behaviour:
- **Reset (async assert, sync release):** state=IDLE; all `mul_*` outputs 0; `rsp_data`=0; `rsp_valid`=0; `busy`=0; round-robin pointer favours requester 0; counter=0.
- **FSM states:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready` = one-hot grant from the round-robin arbiter over `req_valid`. This path is combinational.
  - On a handshake at edge E0: latch the granted requester's operands and modes into the `mul_*` registers, record the owner id, load counter = MUL_LAT-1, go to WAIT.
  - If no request is valid, `req_ready` = 0.
- **WAIT:**
  - `mul_*` outputs are held constant.
  - The counter decrements each cycle.
  - On the edge where the counter is 0 (edge E0+MUL_LAT): `rsp_data` ← `mul_re`, go to RESP.
- **RESP:**
  - `rsp_valid[owner]` = 1; the other bit stays 0.
  - On `rsp_ready[owner]`: go to IDLE and flip the pointer to favour the non-owner.
  - `rsp_ready` of the non-owner is ignored.
- **Not accepted:** `req_ready` = 0 in WAIT and RESP, so there are no overlapping operations. Minimum issue interval is MUL_LAT+2 cycles.
- **Arbitration:**
  - Both requesters valid in IDLE → grant goes to the pointer's requester.
  - Only one valid → that one is granted regardless of the pointer.
  - The pointer changes only on response completion.
- **Requester rules:**
  - Must hold `req_valid` and operands stable until ready.
  - May hold `rsp_ready` high permanently; the response then completes in the first RESP cycle.
- **Output holding:**
  - `mul_*` outputs keep their last operands after completion; they are not cleared.
  - `rsp_data` holds its last value.
- **Reset mid-operation:** the operation is aborted and no response is produced. Requesters must reissue.
- **MUL_LAT=1:** WAIT lasts exactly one cycle.

Optional Feature:
- Macro: **FMUL_ARB_STATS_EN**.
- When defined:
  - Adds outputs `grant_cnt0` and `grant_cnt1` (16 bits each).
  - Each counts completed responses per requester and saturates at 0xFFFF.
  - Both are cleared by `rst_n`.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Decomposition:
- **Shared package `fmul_ctrl_pkg`:**
  - state typedef (IDLE/WAIT/RESP);
  - `NUM_REQ` = 2;
  - default `MUL_LAT`;
  - the counter width constant.
- **Sub-module `rr_arb2`:**
  - Combinational two-input round-robin grant from (`req_valid`, pointer).
  - The pointer register stays in the parent.
- The fmul itself stays outside. The bench instantiates it and connects it to the `mul_*` ports.

Test Plan:
- **Single op:** MUL_LAT=2, req0: 0x3f800000 × 0x40000000, mode_fp=1, round_mode=0.
  - → `req_ready[0]` is high in the same cycle.
  - → `rsp_valid[0]` rises 2 edges after acceptance with `rsp_data`=0x40000000.
  - → `busy` is low again the cycle after the `rsp_ready` handshake.
- **Contention:** req0 = 3.0 × 4.0 (0x40400000, 0x40800000) and req1 = 2.0 × 2.0 asserted together out of reset.
  - → req0 is served first with 0x41400000.
  - → req1 is served next with 0x40800000.
  - → A third simultaneous request is granted to req0.
- **Response backpressure:** hold `rsp_ready[1]` low for 5 cycles.
  - → `rsp_valid[1]` and `rsp_data` stay stable.
  - → `req_ready` stays 0 and a pending req0 is not accepted until the handshake.
- **Reset abort:** assert `rst_n`=0 during WAIT.
  - → Outputs return to reset values immediately (async).
  - → No `rsp_valid` appears after release.
- **MUL_LAT=1:** the 1.0 × 2.0 case → `rsp_valid` rises 1 edge after acceptance.
- **FMUL_ARB_STATS_EN:** run 3 req0 ops and 2 req1 ops → `grant_cnt0`=3, `grant_cnt1`=2.
